// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    // Keeps one-bit minimum so an ID port never collapses to zero width.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin picker: first set bit of req at or after start, wrapping modulo NUM_REQ.
module rr_pick #(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = 2
) (
    input  logic [NUM_REQ-1:0]  req,
    input  logic [ID_WIDTH-1:0] start,
    output logic                found,
    output logic [ID_WIDTH-1:0] idx
);

    localparam logic [ID_WIDTH:0] WRAP = (ID_WIDTH+1)'(NUM_REQ);

    logic [NUM_REQ-1:0]  rotated;
    logic [ID_WIDTH-1:0] offset;
    logic [ID_WIDTH:0]   sum;

    // Rotate so start sits at bit 0, take the lowest set bit, then undo the rotation.
    always_comb begin
        rotated = NUM_REQ'({req, req} >> start);
        found   = 1'b0;
        offset  = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                found  = 1'b1;
                offset = ID_WIDTH'(i);
            end
        end
        sum = {1'b0, start} + {1'b0, offset};
        if (sum >= WRAP) begin
            sum = sum - WRAP;
        end
        idx = sum[ID_WIDTH-1:0];
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers, zero added latency.
// Optional burst lock is built only when ARB_LOCK_EN is defined.
import fifo_arb_pkg::*;

module fifo_wr_arbiter #(
    parameter  int NUM_REQ    = 4,
    parameter  int DATA_WIDTH = 8,
    parameter  int MAX_BURST  = 4,
    localparam int ID_WIDTH   = clog2_min1(NUM_REQ)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_data,
    input  logic [NUM_REQ-1:0]             req_lock,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic                           fifo_full,
    output logic                           fifo_w_en,
    output logic [ID_WIDTH+DATA_WIDTH-1:0] fifo_wdata,
    output logic [ID_WIDTH-1:0]            grant_id,
    output logic                           grant_valid
);

    logic [ID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0]    elig_mask;
    logic                  pick_found;
    logic [ID_WIDTH-1:0]   pick_idx;
    logic                  xfer;
    logic [DATA_WIDTH-1:0] payload;

    function automatic logic [ID_WIDTH-1:0] next_id(input logic [ID_WIDTH-1:0] id);
        return (id == ID_WIDTH'(NUM_REQ - 1)) ? '0 : id + 1'b1;
    endfunction

`ifdef ARB_LOCK_EN
    localparam int CNT_WIDTH = $clog2(MAX_BURST + 1);
    localparam logic [CNT_WIDTH:0] BURST_LIMIT = (CNT_WIDTH+1)'(MAX_BURST);

    arb_state_e           state_q, state_d;
    logic [ID_WIDTH-1:0]  lock_owner_q, lock_owner_d;
    logic [CNT_WIDTH-1:0] burst_cnt_q, burst_cnt_d;
    logic [CNT_WIDTH:0]   cnt_next;

    always_comb begin
        elig_mask = req_valid;
        if (state_q == LOCKED) begin
            elig_mask = req_valid & (NUM_REQ'(1) << lock_owner_q);
        end
    end
`else
    logic unused_lock;
    assign unused_lock = ^req_lock;
    assign elig_mask   = req_valid;
`endif

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_WIDTH(ID_WIDTH)
    ) u_rr_pick (
        .req  (elig_mask),
        .start(rr_ptr_q),
        .found(pick_found),
        .idx  (pick_idx)
    );

    always_comb begin
        payload = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_idx == ID_WIDTH'(i)) begin
                payload = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Gating with rst_n keeps every output at zero while reset is asserted.
    assign xfer        = rst_n & pick_found & ~fifo_full;
    assign grant_valid = xfer;
    assign fifo_w_en   = xfer;
    assign grant_id    = xfer ? pick_idx : '0;
    assign req_ready   = xfer ? (NUM_REQ'(1) << pick_idx) : '0;
    assign fifo_wdata  = xfer ? {pick_idx, payload} : '0;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
`ifdef ARB_LOCK_EN
        state_d      = state_q;
        lock_owner_d = lock_owner_q;
        burst_cnt_d  = burst_cnt_q;
        cnt_next     = {1'b0, burst_cnt_q} + 1'b1;
        case (state_q)
            IDLE: begin
                if (xfer) begin
                    rr_ptr_d = next_id(pick_idx);
                    if (req_lock[pick_idx]) begin
                        state_d      = LOCKED;
                        lock_owner_d = pick_idx;
                        burst_cnt_d  = CNT_WIDTH'(1);
                    end
                end
            end
            LOCKED: begin
                // Without a full FIFO, no transfer here means the owner went idle.
                if (!fifo_full) begin
                    if (xfer && req_lock[lock_owner_q] && (cnt_next < BURST_LIMIT)) begin
                        burst_cnt_d = cnt_next[CNT_WIDTH-1:0];
                    end else begin
                        state_d     = IDLE;
                        rr_ptr_d    = next_id(lock_owner_q);
                        burst_cnt_d = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
`else
        if (xfer) begin
            rr_ptr_d = next_id(pick_idx);
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr_q     <= '0;
`ifdef ARB_LOCK_EN
            state_q      <= IDLE;
            lock_owner_q <= '0;
            burst_cnt_q  <= '0;
`endif
        end else begin
            rr_ptr_q     <= rr_ptr_d;
`ifdef ARB_LOCK_EN
            state_q      <= state_d;
            lock_owner_q <= lock_owner_d;
            burst_cnt_q  <= burst_cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed sequences plus random traffic
// checked against a rule-level model; lock scenarios run when ARB_LOCK_EN is defined.
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int IW = 2;
    localparam int MB = 4;
`ifdef ARB_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_lock;
    logic [N-1:0]    req_ready;
    logic            fifo_full;
    logic            fifo_w_en;
    logic [IW+DW-1:0] fifo_wdata;
    logic [IW-1:0]   grant_id;
    logic            grant_valid;

    int checks = 0;
    int errors = 0;

    logic [IW-1:0] m_ptr    = '0;
    logic [IW-1:0] m_owner  = '0;
    bit            m_locked = 1'b0;
    int            m_cnt    = 0;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(
        .NUM_REQ   (N),
        .DATA_WIDTH(DW),
        .MAX_BURST (MB)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_lock   (req_lock),
        .req_ready  (req_ready),
        .fifo_full  (fifo_full),
        .fifo_w_en  (fifo_w_en),
        .fifo_wdata (fifo_wdata),
        .grant_id   (grant_id),
        .grant_valid(grant_valid)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
            $error("[TB] check %s did not hold", tag);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic [N-1:0] v, input logic [N-1:0] l, input logic f);
        rst_n     = r;
        req_valid = v;
        req_lock  = l;
        fifo_full = f;
        for (int i = 0; i < N; i++) begin
            req_data[i*DW +: DW] = DW'($urandom);
        end
        #4;
    endtask

    // Model: search from the pointer for the first eligible producer, then apply the lock rules.
    task automatic checkOutput();
        logic [N-1:0]     elig;
        logic             gv;
        logic [IW-1:0]    gid;
        logic [N-1:0]     exp_ready;
        logic [IW+DW-1:0] exp_wdata;
        gv   = 1'b0;
        gid  = '0;
        elig = '0;
        if (rst_n) begin
            elig = m_locked ? (req_valid & (N'(1) << m_owner)) : req_valid;
            if (!fifo_full) begin
                for (int k = 0; k < N; k++) begin
                    int c;
                    c = (int'(m_ptr) + k) % N;
                    if (!gv && elig[c]) begin
                        gv  = 1'b1;
                        gid = IW'(c);
                    end
                end
            end
        end
        exp_ready = gv ? (N'(1) << gid) : '0;
        exp_wdata = gv ? {gid, req_data[int'(gid)*DW +: DW]} : '0;
        check("grant_valid", 32'(grant_valid), 32'(gv));
        check("fifo_w_en",   32'(fifo_w_en),   32'(gv));
        check("grant_id",    32'(grant_id),    32'(gv ? gid : '0));
        check("req_ready",   32'(req_ready),   32'(exp_ready));
        check("fifo_wdata",  32'(fifo_wdata),  32'(exp_wdata));

        if (!rst_n) begin
            m_ptr = '0; m_owner = '0; m_locked = 1'b0; m_cnt = 0;
        end else if (m_locked) begin
            if (!fifo_full) begin
                if (gv && req_lock[m_owner] && (m_cnt + 1 < MB)) begin
                    m_cnt++;
                end else begin
                    m_locked = 1'b0;
                    m_cnt    = 0;
                    m_ptr    = IW'((int'(m_owner) + 1) % N);
                end
            end
        end else if (gv) begin
            m_ptr = IW'((int'(gid) + 1) % N);
            if (LOCK_EN && req_lock[gid]) begin
                m_locked = 1'b1;
                m_owner  = gid;
                m_cnt    = 1;
            end
        end
    endtask

    // exp_id >= 0 pins the granted ID; -2 demands no write; -1 relies on the model alone.
    task automatic cycle(input logic r, input logic [N-1:0] v, input logic [N-1:0] l, input logic f, input int exp_id);
        applyStimulus(r, v, l, f);
        checkOutput();
        if (exp_id >= 0) begin
            check("seq_id",  32'(grant_id),  32'(exp_id));
            check("seq_wen", 32'(fifo_w_en), 32'd1);
        end else if (exp_id == -2) begin
            check("idle_wen",   32'(fifo_w_en), 32'd0);
            check("idle_ready", 32'(req_ready), 32'd0);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; req_valid = '0; req_lock = '0; fifo_full = 1'b0; req_data = '0;
        @(posedge clk);
        #1;

        $display("[TB] reset with all producers valid");
        cycle(1'b0, 4'hF, 4'h0, 1'b0, -2);
        cycle(1'b0, 4'hF, 4'h0, 1'b0, -2);

        $display("[TB] full rotation");
        cycle(1'b1, 4'hF, 4'h0, 1'b0, 0);
        cycle(1'b1, 4'hF, 4'h0, 1'b0, 1);
        cycle(1'b1, 4'hF, 4'h0, 1'b0, 2);
        cycle(1'b1, 4'hF, 4'h0, 1'b0, 3);
        cycle(1'b1, 4'hF, 4'h0, 1'b0, 0);

        $display("[TB] sparse requesters with wrap");
        cycle(1'b1, 4'b0010, 4'h0, 1'b0, 1);
        cycle(1'b1, 4'b1010, 4'h0, 1'b0, 3);
        cycle(1'b1, 4'b1010, 4'h0, 1'b0, 1);
        cycle(1'b1, 4'b1010, 4'h0, 1'b0, 3);

        $display("[TB] fifo full stall");
        cycle(1'b1, 4'hF, 4'h0, 1'b0, 0);
        cycle(1'b1, 4'hF, 4'h0, 1'b0, 1);
        cycle(1'b1, 4'hF, 4'h0, 1'b1, -2);
        cycle(1'b1, 4'hF, 4'h0, 1'b1, -2);
        cycle(1'b1, 4'hF, 4'h0, 1'b1, -2);
        cycle(1'b1, 4'hF, 4'h0, 1'b0, 2);

`ifdef ARB_LOCK_EN
        $display("[TB] burst lock to MAX_BURST");
        cycle(1'b1, 4'b1000, 4'h0, 1'b0, 3);
        cycle(1'b1, 4'b0001, 4'h0, 1'b0, 0);
        cycle(1'b1, 4'hF, 4'b0010, 1'b0, 1);
        cycle(1'b1, 4'hF, 4'b0010, 1'b0, 1);
        cycle(1'b1, 4'hF, 4'b0010, 1'b0, 1);
        cycle(1'b1, 4'hF, 4'b0010, 1'b0, 1);
        cycle(1'b1, 4'hF, 4'b0010, 1'b0, 2);
        cycle(1'b1, 4'hF, 4'b0010, 1'b0, 3);
        cycle(1'b1, 4'hF, 4'b0010, 1'b0, 0);
        cycle(1'b1, 4'hF, 4'b0000, 1'b0, 1);

        $display("[TB] lock dropped early");
        cycle(1'b1, 4'b0001, 4'h0, 1'b0, 0);
        cycle(1'b1, 4'hF, 4'b0010, 1'b0, 1);
        cycle(1'b1, 4'hF, 4'b0000, 1'b0, 1);
        cycle(1'b1, 4'hF, 4'b0000, 1'b0, 2);

        $display("[TB] reset abandons lock");
        cycle(1'b1, 4'b0001, 4'h0, 1'b0, 0);
        cycle(1'b1, 4'hF, 4'b0010, 1'b0, 1);
        cycle(1'b1, 4'hF, 4'b0010, 1'b0, 1);
        cycle(1'b0, 4'hF, 4'b0010, 1'b0, -2);
        cycle(1'b1, 4'hF, 4'b0000, 1'b0, 0);
        cycle(1'b1, 4'hF, 4'b0000, 1'b0, 1);
        cycle(1'b1, 4'hF, 4'b0000, 1'b0, 2);
`endif

        $display("[TB] random traffic");
        for (int n = 0; n < 400; n++) begin
            cycle($urandom_range(0, 49) != 0, N'($urandom), N'($urandom & $urandom),
                  $urandom_range(0, 3) == 0, -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
